instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port Clk  input  1  single system clock; all state updates on posedge.
REQ-002 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Addr  output  32  word address to instruction memory; equals {28'b0, pc[3:0]}.
REQ-004 SHALL have port InstrIn  input  32  instruction word returned combinationally by instruction memory for Addr.
REQ-005 SHALL have port Redirect  input  1  execute-stage request to load a new PC (BEQ taken, JAL, JR, J when early jump is disabled).
REQ-006 SHALL have port RedirectAddr  input  32  redirect target; only bits [3:0] are used.
REQ-007 SHALL have port InstrOut  output  32  registered fetched instruction.
REQ-008 SHALL have port PcOut  output  32  registered word address of InstrOut, zero-extended.
REQ-009 SHALL have port Valid  output  1  InstrOut/PcOut hold a live instruction.
REQ-010 SHALL have port Ready  input  1  decode accepts InstrOut this cycle when Valid=1.
REQ-011 SHALL have port Halted  output  1  HALT instruction fetched; fetch stopped.
REQ-012 SHALL have port FetchCount  output  16  number of instructions delivered (Valid&&Ready), saturating at 16'hFFFF.

Function
REQ-013 SHALL implement FSM states INIT, FETCH, HALT.
REQ-014 INIT SHALL last exactly one cycle after Rst_n deasserts, with Valid=0, so memory completes its first-edge load; then FETCH.
REQ-015 In FETCH, when Valid=0 or Ready=1, SHALL capture InstrIn into InstrOut, pc into PcOut, set Valid=1, advance pc (1-cycle latency from Addr to Valid).
REQ-016 When Valid=1 and Ready=0, SHALL hold InstrOut, PcOut, Valid, pc, and Addr unchanged.
REQ-017 pc advance SHALL be pc+1 modulo 16 (15 wraps to 0).
REQ-018 A captured word with opcode [31:26]=6'b111111 SHALL be delivered normally, leave pc unchanged, move to HALT, and set Halted=1.
REQ-019 In HALT, SHALL perform no captures; Valid SHALL clear once the HALT word is accepted (Ready=1).
REQ-020 Redirect=1 SHALL have priority over stall, capture and HALT: next cycle pc=RedirectAddr[3:0], Valid=0, Halted=0, state=FETCH; the instruction in flight is discarded and not counted.
REQ-021 Redirect and Ready both high in one cycle SHALL count the accepted instruction, then flush.
REQ-022 FetchCount SHALL increment on each cycle with Valid&&Ready&&!... (accept), saturating; it SHALL NOT wrap.

Reset
REQ-023 Rst_n=0 SHALL immediately force pc=0, Addr=0, InstrOut=0, PcOut=0, Valid=0, Halted=0, FetchCount=0, state=INIT, regardless of Clk.
REQ-024 Reset asserted mid-stall or mid-HALT SHALL discard all state; no partial instruction survives.

Configuration
REQ-025 Macro IFU_EARLY_JUMP_EN defined: a captured word with opcode 6'b010001 (J) SHALL set next pc=InstrIn[3:0] instead of pc+1; J is still delivered with Valid=1.
REQ-026 Macro IFU_EARLY_JUMP_EN undefined: J SHALL be treated as an ordinary instruction (pc+1); execute redirects via Redirect.

Verification
REQ-027 Reset release, Ready=1, mem[0..2] distinct -> Valid low 1 cycle (INIT), then PcOut=0,1,2 on consecutive cycles with matching InstrOut.
REQ-028 Ready=0 for 3 cycles while Valid=1 at PcOut=4 -> InstrOut, PcOut, Addr=5 frozen; resumes with PcOut=5; FetchCount +1 only for PcOut=4.
REQ-029 Redirect=1, RedirectAddr=7 while stalled at PcOut=12 -> next cycle Valid=0, Addr=7; following cycle PcOut=7; FetchCount unchanged by flush.
REQ-030 mem[13]=J to 7 with IFU_EARLY_JUMP_EN -> PcOut sequence 12,13,7 with no bubble; without macro -> 12,13,14.
REQ-031 HALT opcode at mem[14] -> delivered at PcOut=14, Halted=1, Valid=0 after acceptance, Addr stays 14; Redirect to 0 restarts fetch, Halted=0.
REQ-032 Sequential fetch from pc=15 -> Addr wraps to 0; Rst_n pulsed low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks a 16-word instruction memory and hands one
// registered instruction per cycle to decode under a Valid/Ready handshake.
// Handles execute-stage redirects, the HALT opcode, and a saturating
// delivered-instruction counter.
// Optional build macro: IFU_EARLY_JUMP_EN -- resolve J targets at fetch time.
module instr_fetch_unit (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic [31:0] Addr,
  input  logic [31:0] InstrIn,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic [31:0] InstrOut,
  output logic [31:0] PcOut,
  output logic        Valid,
  input  logic        Ready,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_J    = 6'b010001;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0]  pcout_q, pcout_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] count_q;

  logic [3:0]  pc_seq;
  logic [5:0]  opcode;
  logic        accept;

  // Only the low four redirect bits address the 16-word memory.
  logic        unused_redirect_bits;
  assign unused_redirect_bits = ^RedirectAddr[31:4];

  assign opcode = InstrIn[31:26];
  assign accept = valid_q && Ready;

  // Sequential next pc: either the wrapped increment or an early J target.
  always_comb begin
    pc_seq = pc_q + 4'd1;
`ifdef IFU_EARLY_JUMP_EN
    if (opcode == OP_J) pc_seq = InstrIn[3:0];
`endif
  end

  // Next-state and datapath decisions; a redirect overrides everything else.
  always_comb begin
    // NOTE: every output of this block gets a hold default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcout_d  = pcout_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    if (Redirect) begin
      // The in-flight instruction is dropped; fetch restarts at the target.
      pc_d     = RedirectAddr[3:0];
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = FETCH;
    end else begin
      unique case (state_q)
        INIT: begin
          // One idle cycle lets the memory finish its first-edge load.
          state_d = FETCH;
        end
        FETCH: begin
          if (!valid_q || Ready) begin
            instr_d = InstrIn;
            pcout_d = pc_q;
            valid_d = 1'b1;
            if (opcode == OP_HALT) begin
              // HALT is still delivered, but pc parks on it.
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_seq;
            end
          end
        end
        HALT: begin
          // No further captures; the HALT word drains once decode takes it.
          if (Ready) valid_d = 1'b0;
        end
        default: state_d = INIT;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!Rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // Fetch datapath registers: pc, captured instruction and its address.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q     <= 4'd0;
      instr_q  <= 32'd0;
      pcout_q  <= 4'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcout_q  <= pcout_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Delivered-instruction counter; counts an accept even when it coincides
  // with a redirect, and sticks at all-ones instead of wrapping.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                             count_q <= 16'd0;
    else if (accept && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
  end

  assign Addr       = {28'd0, pc_q};
  assign InstrOut   = instr_q;
  assign PcOut      = {28'd0, pcout_q};
  assign Valid      = valid_q;
  assign Halted     = halted_q;
  assign FetchCount = count_q;

endmodule
